// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises one byte per frame onto tx_bit_o: a start bit,
// DATA_BITS data bits LSB first, an optional parity bit and STOP_BITS stop bits. Each bit
// occupies one tick of the baud clock. A one-entry holding register lets a new byte be
// queued while a frame is on the line, so frames can follow each other without an idle tick.
//
// Ports:
//   tick_i      baud clock; all state changes on its rising edge
//   rst_ni      asynchronous reset, active low
//   tx_en_i     1 = block advances; 0 = all state and outputs frozen, inputs ignored
//   tx_start_i  request to load data_in_i into the holding register (taken when tx_ready_o=1)
//   data_in_i   byte to send; bits above DATA_BITS-1 are ignored
//   tx_ready_o  holding register empty
//   tx_busy_o   frame on the line (start bit through last stop bit)
//   tx_done_o   one-tick pulse after the final stop bit has completed
//   tx_bit_o    serial line, idle high
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       tick_i,
  input  logic       rst_ni,
  input  logic       tx_en_i,
  input  logic       tx_start_i,
  input  logic [7:0] data_in_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_bit_o
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [2:0] DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);
  localparam logic [7:0] DataMask = 8'((1 << DATA_BITS) - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       par_q, par_d;
  logic       tx_bit_q, tx_bit_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_ready_q, tx_ready_d;

  logic accept, load, data_last, stop_last;

  assign accept    = tx_start_i & tx_ready_q;
  assign data_last = (cnt_q == DataLast);
  assign stop_last = (cnt_q == StopLast);
  // Hold moves to the shifter when idle, or at the end of the last stop bit (back-to-back).
  assign load      = hold_valid_q & ((state_q == StIdle) | ((state_q == StStop) & stop_last));

  // State register: everything freezes while tx_en_i is low.
  always_ff @(posedge tick_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      par_q        <= 1'b0;
      tx_bit_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_ready_q   <= 1'b1;
    end else if (tx_en_i) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      par_q        <= par_d;
      tx_bit_q     <= tx_bit_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
      tx_ready_q   <= tx_ready_d;
    end
  end

  // Next-state: sequencing, bit counter, shifter and holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) state_d = StStart;
      end
      StStart: begin
        shift_d = shift_q >> 1;
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        if (data_last) begin
          cnt_d   = '0;
          state_d = PARITY_EN ? StParity : StStop;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          shift_d = shift_q >> 1;
        end
      end
      StParity: begin
        cnt_d   = '0;
        state_d = StStop;
      end
      StStop: begin
        if (stop_last) begin
          cnt_d   = '0;
          state_d = hold_valid_q ? StStart : StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d = hold_q;
      par_d   = (^(hold_q & DataMask)) ^ PARITY_ODD;
    end

    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~load;
    // An accept on the same edge as a transfer refills the hold immediately.
    if (accept) begin
      hold_d       = data_in_i;
      hold_valid_d = 1'b1;
    end
  end

  // Registered outputs: the value each output takes after the coming edge.
  always_comb begin
    tx_bit_d   = tx_bit_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    tx_ready_d = ~hold_valid_d;
    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          tx_bit_d  = 1'b0;
          tx_busy_d = 1'b1;
        end
      end
      StStart: tx_bit_d = shift_q[0];
      StData: begin
        if (data_last) tx_bit_d = PARITY_EN ? par_q : 1'b1;
        else           tx_bit_d = shift_q[0];
      end
      StParity: tx_bit_d = 1'b1;
      StStop: begin
        tx_bit_d = 1'b1;
        if (stop_last) begin
          tx_done_d = 1'b1;
          if (hold_valid_q) tx_bit_d = 1'b0;
          else              tx_busy_d = 1'b0;
        end
      end
      default: tx_bit_d = 1'b1;
    endcase
  end

  assign tx_bit_o   = tx_bit_q;
  assign tx_busy_o  = tx_busy_q;
  assign tx_done_o  = tx_done_q;
  assign tx_ready_o = tx_ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Four instances share one stimulus: 8N1, 8E1, 8O1 and 5N2. A frame-level
// model per instance predicts every output on every tick; directed literal frames pin the model.
module tb_uart_tx;

  logic       tick = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] rdy, busy, done, bitv;

  always #5 tick = ~tick;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8n1 (
    .tick_i(tick), .rst_ni(rst_n), .tx_en_i(tx_en), .tx_start_i(tx_start), .data_in_i(data_in),
    .tx_ready_o(rdy[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]), .tx_bit_o(bitv[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8e1 (
    .tick_i(tick), .rst_ni(rst_n), .tx_en_i(tx_en), .tx_start_i(tx_start), .data_in_i(data_in),
    .tx_ready_o(rdy[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]), .tx_bit_o(bitv[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_8o1 (
    .tick_i(tick), .rst_ni(rst_n), .tx_en_i(tx_en), .tx_start_i(tx_start), .data_in_i(data_in),
    .tx_ready_o(rdy[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]), .tx_bit_o(bitv[2]));
  uart_tx #(.DATA_BITS(5), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_5n2 (
    .tick_i(tick), .rst_ni(rst_n), .tx_en_i(tx_en), .tx_start_i(tx_start), .data_in_i(data_in),
    .tx_ready_o(rdy[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]), .tx_bit_o(bitv[3]));

  int cfg_db[4] = '{8, 8, 8, 5};
  int cfg_pe[4] = '{0, 1, 1, 0};
  int cfg_po[4] = '{0, 0, 1, 0};
  int cfg_sb[4] = '{1, 1, 1, 2};

  int compared = 0;
  int mismatched = 0;

  // Model: the current frame as a list of line levels, one per tick, plus the holding byte.
  logic       m_fr[4][16];
  int         m_len[4];
  int         m_pos[4];
  logic       m_hv[4];
  logic [7:0] m_hb[4];
  logic       m_done[4];

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s @%0t: got timeout expected completion", nm, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_len[d] = 0; m_pos[d] = 0; m_hv[d] = 1'b0; m_hb[d] = 8'h00; m_done[d] = 1'b0;
      for (int k = 0; k < 16; k++) m_fr[d][k] = 1'b1;
    end
  endtask

  task automatic build_frame(input int d, input logic [7:0] b);
    int   k;
    logic p;
    k = 0;
    p = (cfg_po[d] != 0);
    m_fr[d][k] = 1'b0; k++;
    for (int i = 0; i < cfg_db[d]; i++) begin
      m_fr[d][k] = b[i]; p = p ^ b[i]; k++;
    end
    if (cfg_pe[d] != 0) begin m_fr[d][k] = p; k++; end
    for (int s = 0; s < cfg_sb[d]; s++) begin m_fr[d][k] = 1'b1; k++; end
    m_len[d] = k;
    m_pos[d] = 0;
  endtask

  initial model_reset();

  always @(posedge tick or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (tx_en) begin
      for (int d = 0; d < 4; d++) begin
        logic rdy_pre;
        rdy_pre = !m_hv[d];
        m_done[d] = 1'b0;
        if (m_pos[d] < m_len[d]) begin
          m_pos[d]++;
          if (m_pos[d] == m_len[d]) m_done[d] = 1'b1;
        end
        if (m_pos[d] >= m_len[d] && m_hv[d]) begin
          build_frame(d, m_hb[d]);
          m_hv[d] = 1'b0;
        end
        if (tx_start && rdy_pre) begin
          m_hb[d] = data_in;
          m_hv[d] = 1'b1;
        end
      end
    end
  end

  // Per-tick comparison against the model, away from the active edge.
  always @(negedge tick) begin
    for (int d = 0; d < 4; d++) begin
      logic eb;
      if (m_pos[d] < m_len[d]) eb = m_fr[d][m_pos[d]];
      else                     eb = 1'b1;
      check("tx_bit", d, 32'(bitv[d]), 32'(eb));
      check("tx_busy", d, 32'(busy[d]), 32'(m_pos[d] < m_len[d]));
      check("tx_ready", d, 32'(rdy[d]), 32'(!m_hv[d]));
      check("tx_done", d, 32'(done[d]), 32'(m_done[d]));
    end
  end

  // Line receiver on the 8N1 instance for the loopback run.
  logic       rx_on = 1'b0;
  logic       rx_act = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_b = 8'h00;
  int         rx_cnt = 0;
  int         txd_cnt = 0;
  logic [7:0] sent_q[$];

  always @(negedge tick) begin
    if (rx_on) begin
      if (done[0]) txd_cnt++;
      if (!rx_act) begin
        if (bitv[0] == 1'b0) begin rx_act = 1'b1; rx_n = 0; end
      end else begin
        rx_n++;
        if (rx_n <= 8) begin
          rx_b[rx_n-1] = bitv[0];
        end else begin
          rx_act = 1'b0;
          rx_cnt++;
          check("rx_stop", 0, 32'(bitv[0]), 32'd1);
          if (sent_q.size() == 0) check("rx_extra", 0, 32'(rx_b), 32'hFFFF);
          else check("rx_data", 0, 32'(rx_b), 32'(sent_q.pop_front()));
        end
      end
    end
  end

  logic cap_bit[4][32];
  int   cap_busy[4];
  int   cap_done[4];
  int   cap_nrdy[4];

  task automatic capture(input int n);
    for (int d = 0; d < 4; d++) begin cap_busy[d] = 0; cap_done[d] = 0; cap_nrdy[d] = 0; end
    for (int i = 0; i < n; i++) begin
      @(negedge tick);
      for (int d = 0; d < 4; d++) begin
        cap_bit[d][i] = bitv[d];
        cap_busy[d] += int'(busy[d]);
        cap_done[d] += int'(done[d]);
        cap_nrdy[d] += int'(!rdy[d]);
      end
    end
  endtask

  // Expected line levels given in time order as a string of '0'/'1'.
  task automatic check_seq(input string nm, input int d, input string s);
    for (int i = 0; i < s.len(); i++)
      check(nm, d, 32'(cap_bit[d][i]), 32'(s[i] == 8'h31));
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!rdy[0] && n < 100) begin @(posedge tick); #1; n++; end
    if (n >= 100) fail_now("ready_timeout");
    tx_start = 1'b1;
    data_in  = b;
    @(posedge tick); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy != 4'h0 || rdy != 4'hF) && n < 300) begin @(posedge tick); #1; n++; end
    if (n >= 300) fail_now("idle_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end

  initial begin
    // Reset state.
    @(negedge tick);
    for (int d = 0; d < 4; d++) begin
      check("rst_bit", d, 32'(bitv[d]), 32'd1);
      check("rst_ready", d, 32'(rdy[d]), 32'd1);
      check("rst_busy", d, 32'(busy[d]), 32'd0);
      check("rst_done", d, 32'(done[d]), 32'd0);
    end
    @(posedge tick); #1 rst_n = 1'b1;
    @(posedge tick); #1;

    // 0xA5 at 8N1.
    send(8'hA5);
    @(posedge tick);
    capture(11);
    check_seq("a5_frame", 0, "01010010111");
    check("a5_busy_ticks", 0, 32'(cap_busy[0]), 32'd10);
    check("a5_done_pulses", 0, 32'(cap_done[0]), 32'd1);
    @(posedge tick); #1;
    wait_idle();

    // Back-to-back 0x55 then 0x0F.
    send(8'h55);
    fork
      begin @(posedge tick); capture(21); end
      send(8'h0F);
    join
    check_seq("b2b_frames", 0, "010101010101111000011");
    check("b2b_busy_ticks", 0, 32'(cap_busy[0]), 32'd20);
    check("b2b_done_pulses", 0, 32'(cap_done[0]), 32'd2);
    check("b2b_ready_low", 0, 32'(cap_nrdy[0]), 32'd9);
    @(posedge tick); #1;
    wait_idle();

    // Parity: even gives 1, odd gives 0 for 0x07; 5N2 frame for the same byte.
    send(8'h07);
    @(posedge tick);
    capture(12);
    check_seq("p_none", 0, "011100000111");
    check_seq("p_even", 1, "011100000111");
    check_seq("p_odd", 2, "011100000011");
    check_seq("p_5n2", 3, "011100111111");
    check("p_none_ticks", 0, 32'(cap_busy[0]), 32'd10);
    check("p_even_ticks", 1, 32'(cap_busy[1]), 32'd11);
    check("p_odd_ticks", 2, 32'(cap_busy[2]), 32'd11);
    check("p_5n2_ticks", 3, 32'(cap_busy[3]), 32'd8);
    @(posedge tick); #1;
    wait_idle();

    // Freeze mid-DATA for 5 ticks with tx_start asserted.
    send(8'h96);
    repeat (3) begin @(posedge tick); #1; end
    tx_en = 1'b0; tx_start = 1'b1; data_in = 8'hEE;
    repeat (5) begin @(posedge tick); #1; check("frz_busy", 0, 32'(busy[0]), 32'd1); end
    tx_en = 1'b1; tx_start = 1'b0;
    check("frz_ready", 0, 32'(rdy[0]), 32'd1);
    wait_idle();

    // Async reset mid-frame with a byte pending in the hold.
    send(8'h3C);
    send(8'h99);
    repeat (3) begin @(posedge tick); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_bit", 0, 32'(bitv[0]), 32'd1);
    check("arst_ready", 0, 32'(rdy[0]), 32'd1);
    check("arst_busy", 0, 32'(busy[0]), 32'd0);
    @(posedge tick); #1 rst_n = 1'b1;
    @(posedge tick); #1;
    send(8'h81);
    @(posedge tick);
    capture(11);
    check_seq("post_rst_frame", 0, "01000000111");
    check("post_rst_ticks", 0, 32'(cap_busy[0]), 32'd10);
    @(posedge tick); #1;
    wait_idle();

    // Loopback: 256 random bytes, 8N1, back-to-back.
    rx_on = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      send(b);
    end
    wait_idle();
    repeat (2) @(posedge tick);
    rx_on = 1'b0;
    check("rx_frames", 0, 32'(rx_cnt), 32'd256);
    check("tx_done_count", 0, 32'(txd_cnt), 32'd256);
    check("rx_per_done", 0, 32'(rx_cnt), 32'(txd_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
